// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the two-digit 7-segment scanner.
// Holds the scan state enum, the active-high gfedcba segment patterns and a
// small helper used to size the dwell counter.
package seg7_pkg;

    typedef enum logic [1:0] {
        BLANK_T = 2'd0,
        TENS    = 2'd1,
        BLANK_U = 2'd2,
        UNITS   = 2'd3
    } scanState_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_scan2_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to 7-segment decoder (active-high gfedcba).
// Codes 10-15 are not valid BCD and are shown as a dash so a bad upstream
// value is visible on the display rather than silently hidden.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Map each digit to its segment pattern; anything else is a dash
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan2.sv
// seg7_scan2: time-multiplexes a tens and a units BCD digit onto one shared
// 7-segment bus with per-digit anode enables. Each digit is preceded by a
// fully blanked dead time, and both digits are snapshotted together once per
// frame so a counter update mid-frame never shows a torn pair.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks the segments of a
// zero tens digit while keeping the anode timing unchanged.
module seg7_scan2
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYC    = 2,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic       clki,
    input  logic       rs,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_units,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int CNT_W = $clog2(maxOf(SCAN_DIV, DEAD_CYC) + 1);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);

    // Physical line levels for "off"/"inactive" and for each digit's enable
    localparam logic [6:0] SEG_OFF_LVL  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_OFF_LVL   = (AN_ACT_LOW != 0) ? 2'b11 : 2'b00;
    localparam logic [1:0] AN_TENS_LVL  = (AN_ACT_LOW != 0) ? 2'b01 : 2'b10;
    localparam logic [1:0] AN_UNITS_LVL = (AN_ACT_LOW != 0) ? 2'b10 : 2'b01;

    scanState_t       r_state;
    scanState_t       w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic             w_dwellDone;
    logic             w_leaveBlankT;

    logic [3:0]       r_shadowTens;
    logic [3:0]       r_shadowUnits;
    logic [3:0]       w_tensDigit;
    logic [3:0]       w_digit;
    logic [6:0]       w_segRaw;
    logic [6:0]       w_segActive;

    logic [6:0]       w_segNext;
    logic [1:0]       w_anNext;
    logic             w_tickNext;

    logic [6:0]       r_seg;
    logic [1:0]       r_an;
    logic             r_tick;

    // Current state has run its full dwell when the counter hits its last value
    always_comb begin
        w_dwellDone = 1'b0;
        case (r_state)
            BLANK_T, BLANK_U: w_dwellDone = (r_cnt == DEAD_LAST);
            TENS, UNITS:      w_dwellDone = (r_cnt == SCAN_LAST);
            default:          w_dwellDone = 1'b1;
        endcase
    end

    assign w_leaveBlankT = (r_state == BLANK_T) && w_dwellDone;

    // Next-state logic: advance around the fixed four-state ring on dwell end
    always_comb begin
        w_nextState = r_state;
        if (w_dwellDone) begin
            case (r_state)
                BLANK_T: w_nextState = TENS;
                TENS:    w_nextState = BLANK_U;
                BLANK_U: w_nextState = UNITS;
                UNITS:   w_nextState = BLANK_T;
                default: w_nextState = BLANK_T;
            endcase
        end
    end

    // State register and dwell counter; the counter restarts on every state change
    always_ff @(posedge clki or posedge rs) begin
        if (rs) begin
            r_state <= BLANK_T;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_dwellDone) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Capture both digits together on the single edge that leaves BLANK_T
    always_ff @(posedge clki or posedge rs) begin
        if (rs) begin
            r_shadowTens  <= 4'd0;
            r_shadowUnits <= 4'd0;
        end else if (w_leaveBlankT) begin
            r_shadowTens  <= bcd_tens;
            r_shadowUnits <= bcd_units;
        end
    end

    // On the entry edge into TENS the shadow is being loaded, so the decoder
    // must see the value being captured rather than the stale shadow
    assign w_tensDigit = w_leaveBlankT ? bcd_tens : r_shadowTens;
    assign w_digit     = (w_nextState == UNITS) ? r_shadowUnits : w_tensDigit;

    bcd_to_seg7 u_decode (
        .i_bcd (w_digit),
        .o_seg (w_segRaw)
    );

    // Output logic: derive next-cycle outputs from the state being entered
    always_comb begin
        w_segActive = SEG_OFF;
        w_anNext    = AN_OFF_LVL;
        w_tickNext  = 1'b0;
        case (w_nextState)
            TENS: begin
                w_anNext    = AN_TENS_LVL;
                w_segActive = w_segRaw;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (w_tensDigit == 4'd0) begin
                    w_segActive = SEG_OFF;
                end
`endif
                w_tickNext  = w_leaveBlankT;
            end
            UNITS: begin
                w_anNext    = AN_UNITS_LVL;
                w_segActive = w_segRaw;
            end
            default: begin
                w_anNext    = AN_OFF_LVL;
                w_segActive = SEG_OFF;
            end
        endcase
        w_segNext = (SEG_ACT_LOW != 0) ? ~w_segActive : w_segActive;
    end

    // Output registers so the display pins never see a combinational input path
    always_ff @(posedge clki or posedge rs) begin
        if (rs) begin
            r_seg  <= SEG_OFF_LVL;
            r_an   <= AN_OFF_LVL;
            r_tick <= 1'b0;
        end else begin
            r_seg  <= w_segNext;
            r_an   <= w_anNext;
            r_tick <= w_tickNext;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_tick;

endmodule
